// File: rtl/sevenseg_pkg.sv
// Shared constants, address-phase record and glyph decode for the AHB seven-segment scanner.
// Pure declarations: no latency, no flow control.
package sevenseg_pkg;

  localparam logic [5:0] OFF_CTRL  = 6'h00;
  localparam logic [5:0] OFF_DIGEN = 6'h04;
  localparam logic [5:0] OFF_DP    = 6'h08;
  localparam logic [5:0] OFF_BLINK = 6'h0C;
  localparam logic [5:0] OFF_HEX0  = 6'h10;
  localparam logic [5:0] OFF_HEX1  = 6'h14;
  localparam logic [5:0] OFF_RAW0  = 6'h20;
  localparam logic [5:0] OFF_RAW1  = 6'h24;
  localparam logic [5:0] OFF_RAW2  = 6'h28;
  localparam logic [5:0] OFF_RAW3  = 6'h2C;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_HEX     = 1;
  localparam int CTRL_BLINK   = 2;
  localparam int CTRL_BRT_LSB = 4;
  localparam logic [7:0] CTRL_MASK = 8'hF7;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [5:0] addr;
  } ahb_ap_t;

  // Active-high segments, bit 0 = CA .. bit 6 = CG.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  function automatic logic [15:0] digit_mask(input int num_digits);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) if (i < num_digits) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] hex_word_mask(input int num_digits, input int word);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (8 * word + i < num_digits) m[4*i +: 4] = 4'hF;
    return m;
  endfunction

  // Raw bit 7 is not stored: the decimal point always comes from the DP register.
  function automatic logic [31:0] raw_word_mask(input int num_digits, input int word);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (4 * word + i < num_digits) m[8*i +: 8] = 8'h7F;
    return m;
  endfunction

endpackage

// File: rtl/ahb_sevenseg_mux_if.sv
// AHB-Lite slave-side signal bundle for the seven-segment scanner.
// Zero-wait-state bus: no HREADY, the slave never stalls.
interface ahb_sevenseg_mux_if;
  logic [5:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;

  modport master (
    output HADDR, HTRANS, HWDATA, HWRITE, HSEL,
    input  HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HWDATA, HWRITE, HSEL,
    output HRDATA
  );
endinterface

// File: rtl/sevenseg_scan_timer.sv
// Slot prescaler, digit index and blink phase; index and phase move on the slot_wrap cycle edge.
// Free running from reset, no backpressure.
module sevenseg_scan_timer #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SCANS = 64
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  output logic [3:0] index,
  output logic       blink_phase,
  output logic       slot_wrap
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [PRE_W-1:0] presc_q;
  logic [SCN_W-1:0] scan_q;

  assign slot_wrap = (presc_q == PRE_W'(REFRESH_DIV - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc_q     <= '0;
      index       <= '0;
      scan_q      <= '0;
      blink_phase <= 1'b0;
    end else if (slot_wrap) begin
      presc_q <= '0;
      if (index == 4'(NUM_DIGITS - 1)) begin
        // Completed scan: the blink phase flips every BLINK_SCANS of these.
        index <= '0;
        if (scan_q == SCN_W'(BLINK_SCANS - 1)) begin
          scan_q      <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          scan_q <= scan_q + 1'b1;
        end
      end else begin
        index <= index + 1'b1;
      end
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/ahb_sevenseg_mux.sv
// AHB-Lite register block driving a multiplexed common-anode seven-segment array.
// Zero wait states; pins follow any index/PWM/register change one HCLK later.
module ahb_sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_SCANS = 64
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_sevenseg_mux_if.slave     bus,
  output logic [7:0]            IO_7SEG_N,
  output logic [NUM_DIGITS-1:0] IO_7SEGEN_N
);

  localparam logic [15:0]      DIG_MASK = digit_mask(NUM_DIGITS);
  localparam logic [1:0][31:0] HEX_MASK = {hex_word_mask(NUM_DIGITS, 1),
                                           hex_word_mask(NUM_DIGITS, 0)};
  localparam logic [3:0][31:0] RAW_MASK = {raw_word_mask(NUM_DIGITS, 3),
                                           raw_word_mask(NUM_DIGITS, 2),
                                           raw_word_mask(NUM_DIGITS, 1),
                                           raw_word_mask(NUM_DIGITS, 0)};

  ahb_ap_t          ap_q;
  logic             wr_en;
  logic [7:0]       ctrl_q;
  logic [15:0]      digen_q, dp_q, blink_q;
  logic [1:0][31:0] hex_q;
  logic [3:0][31:0] raw_q;
  logic [31:0]      rdata;
  logic [3:0]       pwm_q;
  logic [3:0]       index;
  logic             blink_phase;
  logic             slot_wrap_unused;

  sevenseg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLINK_SCANS (BLINK_SCANS)
  ) u_scan (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .index       (index),
    .blink_phase (blink_phase),
    .slot_wrap   (slot_wrap_unused)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ap_q <= '0;
    else          ap_q <= '{vld:  bus.HSEL && (bus.HTRANS != HTRANS_IDLE),
                            wr:   bus.HWRITE,
                            addr: bus.HADDR};
  end

  assign wr_en = ap_q.vld && ap_q.wr;

  // Storage masks keep bits for absent digits and unused fields at zero.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q  <= '0;
      digen_q <= '0;
      dp_q    <= '0;
      blink_q <= '0;
      hex_q   <= '0;
      raw_q   <= '0;
    end else if (wr_en) begin
      case (ap_q.addr)
        OFF_CTRL:  ctrl_q   <= bus.HWDATA[7:0] & CTRL_MASK;
        OFF_DIGEN: digen_q  <= bus.HWDATA[15:0] & DIG_MASK;
        OFF_DP:    dp_q     <= bus.HWDATA[15:0] & DIG_MASK;
        OFF_BLINK: blink_q  <= bus.HWDATA[15:0] & DIG_MASK;
        OFF_HEX0:  hex_q[0] <= bus.HWDATA & HEX_MASK[0];
        OFF_HEX1:  hex_q[1] <= bus.HWDATA & HEX_MASK[1];
        OFF_RAW0:  raw_q[0] <= bus.HWDATA & RAW_MASK[0];
        OFF_RAW1:  raw_q[1] <= bus.HWDATA & RAW_MASK[1];
        OFF_RAW2:  raw_q[2] <= bus.HWDATA & RAW_MASK[2];
        OFF_RAW3:  raw_q[3] <= bus.HWDATA & RAW_MASK[3];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (ap_q.vld && !ap_q.wr) begin
      case (ap_q.addr)
        OFF_CTRL:  rdata = {24'h0, ctrl_q};
        OFF_DIGEN: rdata = {16'h0, digen_q};
        OFF_DP:    rdata = {16'h0, dp_q};
        OFF_BLINK: rdata = {16'h0, blink_q};
        OFF_HEX0:  rdata = hex_q[0];
        OFF_HEX1:  rdata = hex_q[1];
        OFF_RAW0:  rdata = raw_q[0];
        OFF_RAW1:  rdata = raw_q[1];
        OFF_RAW2:  rdata = raw_q[2];
        OFF_RAW3:  rdata = raw_q[3];
        default:   rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA = rdata;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) pwm_q <= '0;
    else          pwm_q <= pwm_q + 1'b1;
  end

  logic [63:0]           hex_flat;
  logic [127:0]          raw_flat;
  logic [3:0]            nibble;
  logic [6:0]            pattern;
  logic                  lit, blanked, drive;
  logic [7:0]            seg_d;
  logic [NUM_DIGITS-1:0] en_d;

  always_comb begin
    hex_flat = hex_q;
    raw_flat = raw_q;
    nibble   = hex_flat[{index, 2'b00} +: 4];
    pattern  = ctrl_q[CTRL_HEX] ? hex_to_seg(nibble) : raw_flat[{index, 3'b000} +: 7];
    lit      = (pwm_q <= ctrl_q[CTRL_BRT_LSB +: 4]);
    blanked  = ctrl_q[CTRL_BLINK] & blink_q[index] & blink_phase;
    drive    = ctrl_q[CTRL_EN] & digen_q[index] & lit & ~blanked;
    seg_d    = drive ? ~{dp_q[index], pattern} : 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) en_d[i] = ~(drive && (index == 4'(i)));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      IO_7SEG_N   <= 8'hFF;
      IO_7SEGEN_N <= '1;
    end else begin
      IO_7SEG_N   <= seg_d;
      IO_7SEGEN_N <= en_d;
    end
  end

endmodule
